// File: rtl/ren_conv_pkg.sv
// rtl/ren_conv_pkg.sv - shared descriptor layout and scheduler state encoding for ren_conv
package ren_conv_pkg;

  localparam int DESC_W = 40;

  // Field order is MSB first so the struct overlays the 40-bit bus descriptor directly.
  typedef struct packed {
    logic [3:0] tag;
    logic       irq_en;
    logic [2:0] mask;
    logic       en_max_pool;
    logic [3:0] shift;
    logic [5:0] result_cols;
    logic       kern_addr_mode;
    logic [5:0] stride;
    logic [2:0] kerns;
    logic [7:0] cols;
    logic [2:0] kern_cols;
  } desc_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } sched_state_e;

endpackage

// File: rtl/ren_cmd_fifo.sv
// rtl/ren_cmd_fifo.sv - synchronous descriptor FIFO with flush, full/empty and head-of-queue output
module ren_cmd_fifo #(
  parameter int AW = 2,
  parameter int DW = 40
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [1<<AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // A push coinciding with a flush is dropped along with the queue contents.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ren_conv_sched.sv
// rtl/ren_conv_sched.sv - descriptor queue, job FSM, watchdog and completion status in front of ren_conv
module ren_conv_sched #(
  parameter int                    FIFO_AW     = 2,
  parameter int                    DESC_W      = 40,
  parameter int                    TIMEOUT_W   = 16,
  parameter logic [TIMEOUT_W-1:0]  TIMEOUT_CYC = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DESC_W-1:0] cmd_desc,
  input  logic              abort,
  input  logic              irq_clr,
  input  logic              conv_done,
  input  logic              conv_ovf,
  output logic              conv_start,
  output logic              conv_soft_rst,
  output logic [2:0]        cfg_kern_cols,
  output logic [7:0]        cfg_cols,
  output logic [2:0]        cfg_kerns,
  output logic [5:0]        cfg_stride,
  output logic              cfg_kern_addr_mode,
  output logic [5:0]        cfg_result_cols,
  output logic [3:0]        cfg_shift,
  output logic              cfg_en_max_pool,
  output logic [2:0]        cfg_mask,
  output logic              busy,
  output logic [7:0]        job_cnt,
  output logic [3:0]        last_tag,
  output logic              irq,
  output logic              err_timeout,
  output logic              err_ovf
);
  import ren_conv_pkg::*;

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_CYC - 1'b1;

  sched_state_e         state, state_nx;
  logic [DESC_W-1:0]    fifo_head;
  desc_t                head_d;
  logic                 fifo_full, fifo_empty;
  logic                 pop;
  logic                 done_q;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 abort_ph;
  logic [3:0]           cur_tag;
  logic                 cur_irq_en;
  logic                 done_edge, job_done, timeout_hit, irq_set;

  ren_cmd_fifo #(.AW(FIFO_AW), .DW(DESC_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (cmd_valid),
    .pop   (pop),
    .wdata (cmd_desc),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_d      = fifo_head;
  assign cmd_ready   = !fifo_full;
  assign busy        = (state != ST_IDLE) || !fifo_empty;
  assign done_edge   = conv_done && !done_q;
  assign job_done    = (state == ST_DONE) && !abort;
  assign timeout_hit = (state == ST_RUN) && !abort && (wd_cnt == WD_LAST);
  assign irq_set     = (job_done && cur_irq_en) || ((state == ST_ABORT) && abort_ph);

  always_comb begin
    state_nx      = state;
    pop           = 1'b0;
    conv_start    = 1'b0;
    conv_soft_rst = 1'b0;
    case (state)
      ST_IDLE:  if (!fifo_empty && !abort) begin
                  pop      = 1'b1;
                  state_nx = ST_LOAD;
                end
      ST_LOAD:  state_nx = abort ? ST_ABORT : ST_START;
      ST_START: begin
                  conv_start = 1'b1;
                  state_nx   = abort ? ST_ABORT : ST_RUN;
                end
      // Abort outranks a done edge in the same cycle, so that job is never counted.
      ST_RUN:   if (abort || wd_cnt == WD_LAST) state_nx = ST_ABORT;
                else if (done_edge)             state_nx = ST_DONE;
      ST_DONE:  state_nx = abort ? ST_ABORT : ST_IDLE;
      ST_ABORT: begin
                  conv_soft_rst = 1'b1;
                  if (abort_ph) state_nx = ST_IDLE;
                end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      done_q             <= 1'b0;
      wd_cnt             <= '0;
      abort_ph           <= 1'b0;
      cur_tag            <= '0;
      cur_irq_en         <= 1'b0;
      cfg_kern_cols      <= '0;
      cfg_cols           <= '0;
      cfg_kerns          <= '0;
      cfg_stride         <= '0;
      cfg_kern_addr_mode <= 1'b0;
      cfg_result_cols    <= '0;
      cfg_shift          <= '0;
      cfg_en_max_pool    <= 1'b0;
      cfg_mask           <= '0;
      job_cnt            <= '0;
      last_tag           <= '0;
      irq                <= 1'b0;
      err_timeout        <= 1'b0;
      err_ovf            <= 1'b0;
    end else begin
      state    <= state_nx;
      done_q   <= conv_done;
      abort_ph <= (state == ST_ABORT) && !abort_ph;
      if (pop) begin
        cfg_kern_cols      <= head_d.kern_cols;
        cfg_cols           <= head_d.cols;
        cfg_kerns          <= head_d.kerns;
        cfg_stride         <= head_d.stride;
        cfg_kern_addr_mode <= head_d.kern_addr_mode;
        cfg_result_cols    <= head_d.result_cols;
        cfg_shift          <= head_d.shift;
        cfg_en_max_pool    <= head_d.en_max_pool;
        cfg_mask           <= head_d.mask;
        cur_tag            <= head_d.tag;
        cur_irq_en         <= head_d.irq_en;
      end
      if (state == ST_START)    wd_cnt <= '0;
      else if (state == ST_RUN) wd_cnt <= wd_cnt + 1'b1;
      if (job_done) begin
        job_cnt  <= job_cnt + 1'b1;
        last_tag <= cur_tag;
      end
      if (irq_set)      irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
      if (timeout_hit)  err_timeout <= 1'b1;
      else if (irq_clr) err_timeout <= 1'b0;
      if (state == ST_RUN && conv_ovf) err_ovf <= 1'b1;
      else if (irq_clr)                err_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ren_conv_sched.sv
// tb/tb_ren_conv_sched.sv - directed plus randomized descriptor bench for ren_conv_sched with a ren_conv responder
module tb_ren_conv_sched;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, abort, irq_clr, conv_done, conv_ovf;
  logic [39:0] cmd_desc;
  logic        cmd_ready, conv_start, conv_soft_rst, busy, irq, err_timeout, err_ovf;
  logic [2:0]  cfg_kern_cols, cfg_kerns, cfg_mask;
  logic [7:0]  cfg_cols, job_cnt;
  logic [5:0]  cfg_stride, cfg_result_cols;
  logic        cfg_kern_addr_mode, cfg_en_max_pool;
  logic [3:0]  cfg_shift, last_tag;
  logic [34:0] cfg_pack;

  always #5 clk = ~clk;

  ren_conv_sched #(.TIMEOUT_CYC(16'd100)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_desc(cmd_desc),
    .abort(abort), .irq_clr(irq_clr), .conv_done(conv_done), .conv_ovf(conv_ovf),
    .conv_start(conv_start), .conv_soft_rst(conv_soft_rst),
    .cfg_kern_cols(cfg_kern_cols), .cfg_cols(cfg_cols), .cfg_kerns(cfg_kerns), .cfg_stride(cfg_stride),
    .cfg_kern_addr_mode(cfg_kern_addr_mode), .cfg_result_cols(cfg_result_cols), .cfg_shift(cfg_shift),
    .cfg_en_max_pool(cfg_en_max_pool), .cfg_mask(cfg_mask), .busy(busy), .job_cnt(job_cnt),
    .last_tag(last_tag), .irq(irq), .err_timeout(err_timeout), .err_ovf(err_ovf)
  );

  // Config fields reassembled in descriptor bit order [34:0].
  assign cfg_pack = {cfg_mask, cfg_en_max_pool, cfg_shift, cfg_result_cols, cfg_kern_addr_mode,
                     cfg_stride, cfg_kerns, cfg_cols, cfg_kern_cols};

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, n_start = 0, n_srst = 0;
  int          start_t[$];
  logic [34:0] obs_q[$];
  logic [39:0] exp_q[$];
  int          exp_cnt = 0;
  logic [3:0]  exp_tag = '0;
  logic        exp_irq = 1'b0;
  int          resp_delay = 20;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (conv_start) begin
      n_start++;
      start_t.push_back(cyc);
      obs_q.push_back(cfg_pack);
    end
    if (conv_soft_rst) n_srst++;
  end

  // ren_conv stand-in: drops done the cycle after start, raises it resp_delay cycles later (-1 = never).
  initial begin
    int rc;
    bit pend, first;
    conv_done = 1'b0; rc = 0; pend = 0; first = 0;
    forever begin
      @(posedge clk); #2;
      if (conv_start) begin
        rc = resp_delay; pend = 1; first = 1;
      end else if (pend) begin
        if (first) begin conv_done = 1'b0; first = 0; end
        if (rc == 0) begin conv_done = 1'b1; pend = 0; end
        else if (rc > 0) rc--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [39:0] d);
    cmd_desc = d; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    while (!conv_start && lat < 200) begin step(); lat++; end
    chk("start_seen", conv_start, 1'b1);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy && k < bound) begin step(); k++; end
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1; step(); irq_clr = 1'b0; exp_irq = 1'b0;
  endtask

  task automatic model_complete(input logic [39:0] d);
    exp_cnt = (exp_cnt + 1) % 256;
    exp_tag = d[39:36];
    if (d[35]) exp_irq = 1'b1;
  endtask

  task automatic check_jobs(input string tag);
    chk({tag, "_nstart"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_cfg%0d", tag, i), obs_q[i], exp_q[i][34:0]);
    obs_q.delete(); exp_q.delete(); start_t.delete();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_irq"}, irq, 1'b0);
    chk({tag, "_job_cnt"}, job_cnt, 8'd0);
    chk({tag, "_last_tag"}, last_tag, 4'd0);
    chk({tag, "_cfg"}, cfg_pack, 35'd0);
    chk({tag, "_start"}, conv_start, 1'b0);
    chk({tag, "_soft_rst"}, conv_soft_rst, 1'b0);
    chk({tag, "_errs"}, {err_timeout, err_ovf}, 2'b00);
  endtask

  function automatic logic [39:0] rand_desc();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[39:0];
  endfunction

  initial begin
    logic [39:0] d;
    int lat, s0, dly;
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0; irq_clr = 1'b0; conv_ovf = 1'b0; cmd_desc = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_reset_state("rst");

    conv_ovf = 1'b1; step(); conv_ovf = 1'b0; step();
    chk("ovf_idle_ignored", err_ovf, 1'b0);

    // Single job: start 2 cycles after the pop, one completion, irq raised.
    d = rand_desc(); d[10:3] = 8'd8; d[13:11] = 3'd2; d[39:36] = 4'd5; d[35] = 1'b1;
    resp_delay = 20;
    exp_q.push_back(d);
    push(d);
    wait_start(lat);
    chk("t1_start_latency", lat, 2);
    repeat (4) step();
    conv_ovf = 1'b1; step(); conv_ovf = 1'b0;
    wait_idle(100);
    model_complete(d);
    chk("t1_job_cnt", job_cnt, exp_cnt);
    chk("t1_last_tag", last_tag, exp_tag);
    chk("t1_irq", irq, exp_irq);
    chk("t1_err_ovf", err_ovf, 1'b1);
    chk("t1_err_timeout", err_timeout, 1'b0);
    check_jobs("t1");
    clear_irq();
    chk("t1_irq_cleared", {irq, err_ovf}, 2'b00);

    // Leader job running while five more are pushed: the fifth finds the FIFO full.
    dly = $urandom_range(8, 15);
    resp_delay = dly;
    d = rand_desc(); exp_q.push_back(d);
    push(d);
    wait_start(lat);
    for (int k = 0; k < 5; k++) begin
      d = rand_desc();
      chk($sformatf("t2_ready%0d", k), cmd_ready, (k < 4));
      if (k < 4) exp_q.push_back(d);
      push(d);
    end
    wait_idle(400);
    foreach (exp_q[i]) model_complete(exp_q[i]);
    chk("t2_job_cnt", job_cnt, exp_cnt);
    chk("t2_last_tag", last_tag, exp_tag);
    chk("t2_irq", irq, exp_irq);
    chk("t2_cfg_hold", cfg_pack, exp_q[exp_q.size()-1][34:0]);
    for (int i = 1; i < start_t.size(); i++)
      chk($sformatf("t2_gap%0d", i), start_t[i] - start_t[i-1], dly + 5);
    check_jobs("t2");
    clear_irq();

    // Watchdog: done never rises, RUN lasts 100 cycles then a 2-cycle soft reset.
    resp_delay = -1;
    d = rand_desc(); exp_q.push_back(d);
    push(d);
    wait_start(lat);
    s0 = n_srst;
    repeat (100) step();
    chk("t3_no_srst_at_100", conv_soft_rst, 1'b0);
    chk("t3_no_timeout_at_100", err_timeout, 1'b0);
    step();
    chk("t3_srst_at_101", conv_soft_rst, 1'b1);
    step(); step();
    exp_irq = 1'b1;
    chk("t3_srst_cycles", n_srst - s0, 2);
    chk("t3_err_timeout", err_timeout, 1'b1);
    chk("t3_irq", irq, exp_irq);
    chk("t3_job_cnt", job_cnt, exp_cnt);
    chk("t3_busy", busy, 1'b0);
    check_jobs("t3");
    clear_irq();
    chk("t3_cleared", {irq, err_timeout, err_ovf}, 3'b000);

    // Abort with two queued jobs, in the same cycle the done edge arrives.
    resp_delay = 10;
    d = rand_desc(); exp_q.push_back(d);
    push(d);
    wait_start(lat);
    s0 = n_srst;
    push(rand_desc());
    push(rand_desc());
    repeat (9) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("t4_srst", conv_soft_rst, 1'b1);
    step(); step();
    exp_irq = 1'b1;
    chk("t4_srst_cycles", n_srst - s0, 2);
    chk("t4_busy", busy, 1'b0);
    chk("t4_job_cnt", job_cnt, exp_cnt);
    chk("t4_irq", irq, exp_irq);
    chk("t4_cmd_ready", cmd_ready, 1'b1);
    repeat (20) step();
    check_jobs("t4");
    clear_irq();

    // irq_clr landing in the DONE cycle loses to the set.
    dly = $urandom_range(3, 12);
    resp_delay = dly;
    d = rand_desc(); d[35] = 1'b1; exp_q.push_back(d);
    push(d);
    wait_start(lat);
    repeat (dly + 2) step();
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    model_complete(d);
    chk("t5_irq_set_wins", irq, 1'b1);
    chk("t5_job_cnt", job_cnt, exp_cnt);
    step();
    clear_irq();
    chk("t5_cleared", {irq, err_timeout, err_ovf}, 3'b000);
    check_jobs("t5");

    // Synchronous reset mid-RUN with one job still queued.
    resp_delay = 30;
    d = rand_desc(); exp_q.push_back(d);
    push(d);
    wait_start(lat);
    push(rand_desc());
    repeat (4) step();
    reset = 1'b1; step(); reset = 1'b0;
    exp_cnt = 0; exp_tag = '0; exp_irq = 1'b0;
    check_reset_state("t6");
    repeat (40) step();
    check_jobs("t6");

    // 256 short jobs: job_cnt reaches 255 then wraps to 0.
    resp_delay = 1;
    for (int i = 0; i < 256; i++) begin
      d = rand_desc(); exp_q.push_back(d);
      push(d);
      wait_idle(50);
      model_complete(d);
      if (i == 254) chk("t7_cnt_255", job_cnt, 8'd255);
    end
    chk("t7_cnt_wrap", job_cnt, exp_cnt);
    chk("t7_last_tag", last_tag, exp_tag);
    chk("t7_irq", irq, exp_irq);
    check_jobs("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
